// File: rtl/cnt_wrap_tracker.sv
// Monitor for the 4-bit up/down counter: widens the count with a signed wrap epoch,
// checks each count step and rollover pulse, and queues wrap/error events in a FIFO.
module cnt_wrap_tracker #(
  parameter int CNT_W   = 4,
  parameter int EPOCH_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mon_en,
  input  logic [CNT_W-1:0]           cnt_load,
  input  logic                       cnt_load_en,
  input  logic                       cnt_down,
  input  logic [CNT_W-1:0]           cnt_count,
  input  logic                       cnt_rollover,
  output logic [EPOCH_W+CNT_W-1:0]   ext_count,
  output logic                       evt_valid,
  output logic [2+EPOCH_W+CNT_W-1:0] evt_data,
  input  logic                       evt_ready,
  output logic [7:0]                 err_cnt,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + EPOCH_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;

  localparam logic [1:0] EV_WRAP_UP  = 2'd0;
  localparam logic [1:0] EV_WRAP_DN  = 2'd1;
  localparam logic [1:0] EV_STEP_ERR = 2'd2;
  localparam logic [1:0] EV_ROLL_ERR = 2'd3;

  logic [1:0]         state;
  logic [EPOCH_W-1:0] epoch;
  logic [CNT_W-1:0]   prev_count;
  logic [CNT_W-1:0]   prev_load;
  logic               prev_load_en;
  logic               prev_down;

  logic [EW-1:0]      mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;

  logic               tracking;
  logic [CNT_W-1:0]   exp_count;
  logic               wrap_up;
  logic               wrap_dn;
  logic               step_err;
  logic               roll_err;
  logic [EPOCH_W-1:0] epoch_next;
  logic               push;
  logic [1:0]         push_type;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;

  // NOTE: every signal gets a default before any conditional assignment, otherwise
  // a path that skips it would infer a latch.
  always_comb begin
    tracking   = (state == S_TRACK) && mon_en;
    exp_count  = prev_load_en ? prev_load
               : (prev_down ? prev_count - CNT_W'(1) : prev_count + CNT_W'(1));
    wrap_up    = tracking && !prev_load_en && !prev_down && (prev_count == CNT_MAX);
    wrap_dn    = tracking && !prev_load_en &&  prev_down && (prev_count == '0);
    step_err   = tracking && (cnt_count != exp_count);
    roll_err   = tracking && (cnt_rollover != (wrap_up || wrap_dn));
    epoch_next = epoch;
    if (wrap_up)      epoch_next = epoch + EPOCH_W'(1);
    else if (wrap_dn) epoch_next = epoch - EPOCH_W'(1);

    push      = step_err || roll_err || wrap_up || wrap_dn;
    push_type = EV_WRAP_DN;
    if (step_err)      push_type = EV_STEP_ERR;
    else if (roll_err) push_type = EV_ROLL_ERR;
    else if (wrap_up)  push_type = EV_WRAP_UP;

    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !fifo_empty && evt_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_ok    = push && (!fifo_full || pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      epoch        <= '0;
      prev_count   <= '0;
      prev_load    <= '0;
      prev_load_en <= 1'b0;
      prev_down    <= 1'b0;
      ext_count    <= '0;
      err_cnt      <= '0;
      ovf          <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      if (!mon_en) begin
        state     <= S_IDLE;
        epoch     <= '0;
        ext_count <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_PRIME;
            ext_count <= '0;
          end
          S_PRIME, S_TRACK: begin
            state        <= S_TRACK;
            epoch        <= epoch_next;
            prev_count   <= cnt_count;
            prev_load    <= cnt_load;
            prev_load_en <= cnt_load_en;
            prev_down    <= cnt_down;
            ext_count    <= {epoch_next, cnt_count};
          end
          default: begin
            state     <= S_IDLE;
            epoch     <= '0;
            ext_count <= '0;
          end
        endcase
      end

      if ((step_err || roll_err) && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries
  // are valid, and evt_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr[AW-1:0]] <= {push_type, epoch_next, cnt_count};
  end

  assign evt_valid = !fifo_empty;
  assign evt_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_cnt_wrap_tracker.sv
// Directed bench for cnt_wrap_tracker: the counter is emulated by hand-written
// count/rollover vectors and every output is compared against hand-computed values.
module tb_cnt_wrap_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       mon_en;
  logic [3:0] cnt_load;
  logic       cnt_load_en;
  logic       cnt_down;
  logic [3:0] cnt_count;
  logic       cnt_rollover;
  logic [7:0] ext_count;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic       evt_ready;
  logic [7:0] err_cnt;
  logic       ovf;

  int n_pass  = 0;
  int n_total = 0;

  cnt_wrap_tracker #(.CNT_W(4), .EPOCH_W(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mon_en       (mon_en),
    .cnt_load     (cnt_load),
    .cnt_load_en  (cnt_load_en),
    .cnt_down     (cnt_down),
    .cnt_count    (cnt_count),
    .cnt_rollover (cnt_rollover),
    .ext_count    (ext_count),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .err_cnt      (err_cnt),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Present one counter sample, clock it in, and settle just after the edge.
  task automatic cyc(input logic [3:0] cnt, input logic roll);
    cnt_count    = cnt;
    cnt_rollover = roll;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++; if (ext_count !== 8'h00) $display("FAIL reset_ext: got %h want 00", ext_count); else n_pass++;
    n_total++; if (evt_valid !== 1'b0)  $display("FAIL reset_valid: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 10'h000) $display("FAIL reset_data: got %h want 000", evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd0)    $display("FAIL reset_err: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (ovf !== 1'b0)        $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_up_wrap();
    rst = 1'b0; cnt_down = 1'b0; cnt_load_en = 1'b0; evt_ready = 1'b0;
    mon_en = 1'b1;
    cyc(4'hC, 1'b0);
    cyc(4'hD, 1'b0);
    cyc(4'hE, 1'b0);
    cyc(4'hF, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL up_no_evt: got %b want 0", evt_valid); else n_pass++;
    cyc(4'h0, 1'b1);
    n_total++; if (ext_count !== 8'h10) $display("FAIL up_ext: got %h want 10", ext_count); else n_pass++;
    n_total++; if (evt_valid !== 1'b1) $display("FAIL up_valid: got %b want 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 10'h010) $display("FAIL up_data: got %h want 010", evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL up_err: got %0d want 0", err_cnt); else n_pass++;
    evt_ready = 1'b1;
    cyc(4'h1, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL up_drain: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (ext_count !== 8'h11) $display("FAIL up_ext2: got %h want 11", ext_count); else n_pass++;
    evt_ready = 1'b0;
    mon_en = 1'b0;
    cyc(4'h1, 1'b0);
    n_total++; if (ext_count !== 8'h00) $display("FAIL up_idle_ext: got %h want 00", ext_count); else n_pass++;
  endtask

  task automatic test_down_wrap();
    cnt_down = 1'b1;
    mon_en = 1'b1;
    cyc(4'h2, 1'b0);
    cyc(4'h1, 1'b0);
    cyc(4'h0, 1'b0);
    cyc(4'hF, 1'b1);
    n_total++; if (ext_count !== 8'hFF) $display("FAIL dn_ext: got %h want ff", ext_count); else n_pass++;
    n_total++; if (evt_valid !== 1'b1) $display("FAIL dn_valid: got %b want 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 10'h1FF) $display("FAIL dn_data: got %h want 1ff", evt_data); else n_pass++;
    evt_ready = 1'b1;
    cyc(4'hE, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL dn_drain: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (ext_count !== 8'hFE) $display("FAIL dn_ext2: got %h want fe", ext_count); else n_pass++;
    evt_ready = 1'b0;
    mon_en = 1'b0;
    cyc(4'hE, 1'b0);
    cnt_down = 1'b0;
  endtask

  task automatic test_load_step_err();
    mon_en = 1'b1;
    cyc(4'h2, 1'b0);
    cnt_load = 4'h9; cnt_load_en = 1'b1;
    cyc(4'h3, 1'b0);
    cnt_load_en = 1'b0;
    cyc(4'h9, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL load_no_evt: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (err_cnt !== 8'd0) $display("FAIL load_err: got %0d want 0", err_cnt); else n_pass++;
    cyc(4'h5, 1'b0);
    n_total++; if (evt_valid !== 1'b1) $display("FAIL step_valid: got %b want 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 10'h205) $display("FAIL step_data: got %h want 205", evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd1) $display("FAIL step_err: got %0d want 1", err_cnt); else n_pass++;
    n_total++; if (ext_count !== 8'h05) $display("FAIL step_ext: got %h want 05", ext_count); else n_pass++;
    evt_ready = 1'b1;
    cyc(4'h6, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL step_drain: got %b want 0", evt_valid); else n_pass++;
    evt_ready = 1'b0;
    mon_en = 1'b0;
    cyc(4'h6, 1'b0);
  endtask

  task automatic test_roll_err();
    mon_en = 1'b1;
    cyc(4'h3, 1'b0);
    cyc(4'h4, 1'b0);
    cyc(4'h5, 1'b1);
    n_total++; if (evt_data !== 10'h305) $display("FAIL roll_spur_data: got %h want 305", evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd2) $display("FAIL roll_spur_err: got %0d want 2", err_cnt); else n_pass++;
    evt_ready = 1'b1;
    for (int v = 6; v < 16; v++) cyc(4'(v), 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL roll_drain: got %b want 0", evt_valid); else n_pass++;
    cyc(4'h0, 1'b0);
    n_total++; if (evt_data !== 10'h310) $display("FAIL roll_miss_data: got %h want 310", evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd3) $display("FAIL roll_miss_err: got %0d want 3", err_cnt); else n_pass++;
    n_total++; if (ext_count !== 8'h10) $display("FAIL roll_miss_ext: got %h want 10", ext_count); else n_pass++;
    cyc(4'h1, 1'b0);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL roll_drain2: got %b want 0", evt_valid); else n_pass++;
    evt_ready = 1'b0;
    mon_en = 1'b0;
    cyc(4'h1, 1'b0);
  endtask

  // One wrap per two cycles: wrap F->0, then reload F so the next step wraps again.
  task automatic wrap_once();
    cnt_load = 4'hF; cnt_load_en = 1'b1;
    cyc(4'h0, 1'b1);
    cnt_load_en = 1'b0;
    cyc(4'hF, 1'b0);
  endtask

  task automatic test_fifo_full();
    logic [9:0] exp_data;
    mon_en = 1'b1; evt_ready = 1'b0;
    cyc(4'hE, 1'b0);
    cyc(4'hF, 1'b0);
    for (int i = 0; i < 4; i++) wrap_once();
    n_total++; if (ovf !== 1'b0) $display("FAIL full4_ovf: got %b want 0", ovf); else n_pass++;
    wrap_once();
    n_total++; if (ovf !== 1'b1) $display("FAIL full5_ovf: got %b want 1", ovf); else n_pass++;
    n_total++; if (evt_data !== 10'h010) $display("FAIL full_head: got %h want 010", evt_data); else n_pass++;
    n_total++; if (ext_count !== 8'h5F) $display("FAIL full_ext: got %h want 5f", ext_count); else n_pass++;
    mon_en = 1'b0; evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_data = 10'(i << 4);
      n_total++; if (evt_valid !== 1'b1 || evt_data !== exp_data)
        $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, evt_valid, evt_data, exp_data); else n_pass++;
      cyc(4'h0, 1'b0);
    end
    n_total++; if (evt_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", evt_valid); else n_pass++;

    // Refill to full, then push and pop on the same edge.
    evt_ready = 1'b0; mon_en = 1'b1;
    cyc(4'hE, 1'b0);
    cyc(4'hF, 1'b0);
    for (int i = 0; i < 4; i++) wrap_once();
    cnt_load = 4'hF; cnt_load_en = 1'b1; evt_ready = 1'b1;
    cyc(4'h0, 1'b1);
    cnt_load_en = 1'b0; evt_ready = 1'b0; mon_en = 1'b0;
    cyc(4'hF, 1'b0);
    evt_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      exp_data = 10'(i << 4);
      n_total++; if (evt_valid !== 1'b1 || evt_data !== exp_data)
        $display("FAIL pp_drain_%0d: got v=%b d=%h want v=1 d=%h", i, evt_valid, evt_data, exp_data); else n_pass++;
      cyc(4'h0, 1'b0);
    end
    n_total++; if (evt_valid !== 1'b0) $display("FAIL pp_empty: got %b want 0", evt_valid); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
    evt_ready = 1'b0;
  endtask

  task automatic test_mon_en_rst();
    mon_en = 1'b1;
    cyc(4'hE, 1'b0);
    cyc(4'hF, 1'b0);
    cyc(4'h0, 1'b1);
    n_total++; if (ext_count !== 8'h10) $display("FAIL mon_ext: got %h want 10", ext_count); else n_pass++;
    mon_en = 1'b0;
    cyc(4'h1, 1'b0);
    n_total++; if (ext_count !== 8'h00) $display("FAIL mon_off_ext: got %h want 00", ext_count); else n_pass++;
    n_total++; if (evt_valid !== 1'b1 || evt_data !== 10'h010)
      $display("FAIL mon_off_keep: got v=%b d=%h want v=1 d=010", evt_valid, evt_data); else n_pass++;
    n_total++; if (err_cnt !== 8'd3) $display("FAIL mon_off_err: got %0d want 3", err_cnt); else n_pass++;
    rst = 1'b1; evt_ready = 1'b1;
    cyc(4'h2, 1'b0);
    evt_ready = 1'b0;
    test_reset();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mon_en = 1'b0; cnt_load = '0; cnt_load_en = 1'b0; cnt_down = 1'b0;
    cnt_count = '0; cnt_rollover = 1'b0; evt_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_step_err();
    test_roll_err();
    test_fifo_full();
    test_mon_en_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
